// File: rtl/pulse_delay_timer_pkg.sv
// Shared types and widths for the pulse-delay timer.
// DELAY_W_DEF matches the pulse-delay PIO output width.
package pulse_delay_pkg;

   localparam int DELAY_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_e;

endpackage

// File: rtl/pulse_delay_timer_if.sv
// Bus between the pulse-delay PIO and the timer.
// master drives delay/enable; slave returns tick/LED/status.
interface pulse_delay_timer_if
   import pulse_delay_pkg::*;
#(
   parameter int DELAY_W = DELAY_W_DEF
);

   logic [DELAY_W-1:0] delay_in;
   logic               enable;
   logic               tick;
   logic               led_out;
   logic               running;
   logic [DELAY_W-1:0] cur_count;

   modport master (
      output delay_in,
      output enable,
      input  tick,
      input  led_out,
      input  running,
      input  cur_count
   );

   modport slave (
      input  delay_in,
      input  enable,
      output tick,
      output led_out,
      output running,
      output cur_count
   );

endinterface

// File: rtl/pulse_delay_timer.sv
// Periodic one-cycle tick and LED toggle from a PIO delay value.
// Period changes land only at period boundaries.
module pulse_delay_timer
   import pulse_delay_pkg::*;
#(
   parameter int   DELAY_W       = DELAY_W_DEF,
   parameter logic LED_RESET_VAL = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   pulse_delay_timer_if.slave bus
);

   localparam logic [DELAY_W-1:0] ONE  = DELAY_W'(1);
   localparam logic [DELAY_W-1:0] ZERO = '0;

   state_e             state_q;
   state_e             state_d;
   logic [DELAY_W-1:0] delay_q;
   logic [DELAY_W-1:0] active_q;
   logic [DELAY_W-1:0] active_d;
   logic [DELAY_W-1:0] count_q;
   logic [DELAY_W-1:0] count_d;
   logic               tick_q;
   logic               tick_d;
   logic               led_q;
   logic               led_d;
   logic               running_q;
   logic               terminal;
   logic               delay_zero;

   // active is never zero in RUN, so active-1 cannot underflow there.
   assign terminal   = (count_q == (active_q - ONE));
   assign delay_zero = (delay_q == ZERO);

   // Input register: the FSM only ever sees the registered delay.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         delay_q <= ZERO;
      end else begin
         delay_q <= bus.delay_in;
      end
   end

   // Next-state, counter and output decode.
   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      count_d  = count_q;
      tick_d   = 1'b0;
      led_d    = led_q;
      unique case (state_q)
         IDLE: begin
            count_d = ZERO;
            if (bus.enable && !delay_zero) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            active_d = delay_q;
            count_d  = ZERO;
            // A zero delay here would leave RUN with no valid period.
            if (!bus.enable || delay_zero) begin
               state_d = IDLE;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!bus.enable) begin
               state_d = IDLE;
               count_d = ZERO;
            end else if (terminal) begin
               tick_d   = 1'b1;
               led_d    = ~led_q;
               count_d  = ZERO;
               active_d = delay_q;
               if (delay_zero) begin
                  state_d = IDLE;
               end
            end else begin
               count_d = count_q + ONE;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = ZERO;
         end
      endcase
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         active_q  <= ZERO;
         count_q   <= ZERO;
         tick_q    <= 1'b0;
         led_q     <= LED_RESET_VAL;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         count_q   <= count_d;
         tick_q    <= tick_d;
         led_q     <= led_d;
         running_q <= (state_d != IDLE);
      end
   end

   assign bus.tick      = tick_q;
   assign bus.led_out   = led_q;
   assign bus.running   = running_q;
   assign bus.cur_count = count_q;

endmodule

// File: tb/tb_pulse_delay_timer.sv
// Directed and randomized bench for pulse_delay_timer.
// A cycle-level behavioural model is compared every cycle.
module tb_pulse_delay_timer;
   import pulse_delay_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic reset_n = 1'b1;

   pulse_delay_timer_if #(.DELAY_W(W)) bus ();

   pulse_delay_timer #(
      .DELAY_W(W),
      .LED_RESET_VAL(1'b0)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
      end
   endtask

   // Behavioural model: phase 0 stopped, 1 starting, 2 timing.
   // el = cycles elapsed in the current period, per = period length.
   int unsigned m_dq;
   int unsigned m_per;
   int unsigned m_el;
   int          m_ph;
   bit          m_tick;
   bit          m_led;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_dq = 0; m_per = 0; m_el = 0; m_ph = 0;
         m_tick = 0; m_led = 0;
      end else begin
         m_tick = 0;
         if (m_ph == 0) begin
            m_el = 0;
            if (bus.enable && m_dq != 0) m_ph = 1;
         end else if (m_ph == 1) begin
            m_per = m_dq;
            m_el = 0;
            m_ph = (bus.enable && m_dq != 0) ? 2 : 0;
         end else begin
            if (!bus.enable) begin
               m_ph = 0;
               m_el = 0;
            end else if (m_el + 1 == m_per) begin
               m_tick = 1;
               m_led = !m_led;
               m_el = 0;
               m_per = m_dq;
               if (m_dq == 0) m_ph = 0;
            end else begin
               m_el++;
            end
         end
         m_dq = bus.delay_in;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("m_tick", W'(bus.tick), W'(m_tick));
      chk("m_led", W'(bus.led_out), W'(m_led));
      chk("m_running", W'(bus.running), W'(m_ph != 0));
      chk("m_count", bus.cur_count, W'(m_el));
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_tick(input int maxc, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.tick && n < maxc);
      if (!bus.tick) begin
         checks++;
         errors++;
         $display("FAIL tick_timeout: no tick in %0d cycles", maxc);
      end
   endtask

   task automatic wait_cnt(input int target, input int maxc, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.cur_count != W'(target) && n < maxc);
      if (bus.cur_count != W'(target)) begin
         checks++;
         errors++;
         $display("FAIL cnt_timeout: count %0d not seen", target);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int  n;
   int  a;
   bit  led_s;

   initial begin
      bus.delay_in = 4;
      bus.enable   = 1'b0;
      #1 reset_n = 1'b0;
      cyc(4);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("rst_tick", W'(bus.tick), 0);
         chk("rst_led", W'(bus.led_out), 0);
         chk("rst_run", W'(bus.running), 0);
         chk("rst_cnt", bus.cur_count, 0);
      end

      // delay 4: first tick 6 cycles after enable, then every 4
      bus.enable = 1'b1;
      wait_tick(50, n);
      chk("d4_first", W'(n), 6);
      chk("d4_led1", W'(bus.led_out), 1);
      wait_tick(50, n);
      chk("d4_per1", W'(n), 4);
      chk("d4_led2", W'(bus.led_out), 0);
      wait_tick(50, n);
      chk("d4_per2", W'(n), 4);
      @(negedge clk);
      chk("d4_width", W'(bus.tick), 0);
      bus.enable = 1'b0;
      cyc(3);

      // delay 1: tick every cycle
      bus.delay_in = 1;
      cyc(2);
      bus.enable = 1'b1;
      wait_tick(50, n);
      chk("d1_first", W'(n), 3);
      for (int i = 0; i < 8; i++) begin
         led_s = bus.led_out;
         @(negedge clk);
         chk("d1_tick", W'(bus.tick), 1);
         chk("d1_led", W'(bus.led_out), W'(!led_s));
      end
      bus.enable = 1'b0;
      cyc(3);

      // delay 10 changed to 3 mid-period
      bus.delay_in = 10;
      cyc(2);
      bus.enable = 1'b1;
      wait_tick(50, n);
      chk("d10_first", W'(n), 12);
      wait_cnt(2, 50, a);
      bus.delay_in = 3;
      wait_tick(50, n);
      chk("d10_keep", W'(a + n), 10);
      wait_tick(50, n);
      chk("d3_per1", W'(n), 3);
      wait_tick(50, n);
      chk("d3_per2", W'(n), 3);
      bus.enable = 1'b0;
      cyc(3);

      // delay 5 then zero: one final tick, then stop
      bus.delay_in = 5;
      cyc(2);
      bus.enable = 1'b1;
      wait_tick(50, n);
      cyc(2);
      bus.delay_in = 0;
      wait_tick(50, n);
      chk("d0_final", W'(2 + n), 5);
      chk("d0_run", W'(bus.running), 0);
      led_s = bus.led_out;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk("d0_notick", W'(bus.tick), 0);
         chk("d0_hold", W'(bus.led_out), W'(led_s));
      end
      bus.enable = 1'b0;
      cyc(2);

      // delay 8, drop enable on the terminal cycle
      bus.delay_in = 8;
      cyc(2);
      bus.enable = 1'b1;
      wait_tick(50, n);
      chk("d8_first", W'(n), 10);
      wait_cnt(7, 50, a);
      chk("d8_term", W'(a), 7);
      led_s = bus.led_out;
      bus.enable = 1'b0;
      @(negedge clk);
      chk("ab_tick", W'(bus.tick), 0);
      chk("ab_led", W'(bus.led_out), W'(led_s));
      chk("ab_run", W'(bus.running), 0);
      cyc(2);
      bus.enable = 1'b1;
      wait_tick(50, n);
      chk("ab_restart", W'(n), 10);

      // reset mid-period
      bus.delay_in = 6;
      wait_cnt(3, 50, a);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mr_tick", W'(bus.tick), 0);
      chk("mr_led", W'(bus.led_out), 0);
      chk("mr_run", W'(bus.running), 0);
      chk("mr_cnt", bus.cur_count, 0);
      reset_n = 1'b1;
      bus.enable = 1'b0;
      cyc(2);

      // randomized run
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if ($urandom_range(15) == 0) bus.delay_in = W'($urandom_range(7));
         if ($urandom_range(39) == 0) bus.enable = !bus.enable;
         if ($urandom_range(599) == 0) begin
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_delay_timer.md
Name: pulse_delay_timer

Overview:
- Consumes the 32-bit pulse-delay value from the HPS-written pulse-delay PIO output port and turns it into a periodic one-cycle tick and a toggling LED drive.
- Sits directly downstream of the PIO in the blinky fabric path and feeds the LED pins.
- The delay is a period in clk cycles. Period changes take effect glitch-free, only at period boundaries.

Parameters:
- DELAY_W, 32: width of the delay value, counter and active-period register.
- LED_RESET_VAL, 1'b0: level of led_out after reset.

Ports:
- clk  input  1  system clock; same domain as the PIO.
- reset_n  input  1  reset, asynchronous, active-low.
- delay_in  input  DELAY_W  period in clk cycles, driven by the PIO out_port.
- enable  input  1  run request; level-sensitive.
- tick  output  1  one-cycle pulse at the end of each period.
- led_out  output  1  toggles on every tick.
- running  output  1  high while in LOAD or RUN.
- cur_count  output  DELAY_W  current counter value, for debug/readback.

Behaviour:
- Reset (async assert, sync release): state=IDLE, delay_q=0, active=0, count=0, tick=0, led_out=LED_RESET_VAL, running=0.
- delay_in is registered once into delay_q every cycle. The FSM uses only delay_q.
- All outputs are registered. There is no combinational path from inputs to outputs.
- FSM states are IDLE, LOAD, RUN.
- IDLE:
  - count=0, tick=0, led_out holds.
  - Go to LOAD when enable=1 and delay_q!=0.
- LOAD (exactly 1 cycle):
  - active<=delay_q, count<=0, then go to RUN.
  - If enable=0 in this cycle, go to IDLE instead.
- RUN:
  - If enable=0: go to IDLE next edge, count<=0, no tick. An aborted partial period never produces a tick.
  - Else if count==active-1 (terminal): tick<=1 for one cycle, led_out<=~led_out, count<=0, active<=delay_q.
    - If delay_q==0 at terminal, go to IDLE after issuing this final tick.
  - Else: count<=count+1, tick<=0.
- Period = active cycles between successive tick pulses.
  - active=1 gives tick high every cycle and led_out toggling every cycle.
- Latency: enable sampled high in IDLE at edge E0 (delay_q=D) gives LOAD at E0, RUN at E1, and the first tick high in the cycle after edge E1+D.
- A delay change mid-period never shortens or extends the current period; it applies from the next period.
- A delay change while IDLE is picked up at the next LOAD.
- Arithmetic:
  - The count comparison uses active-1 computed at DELAY_W bits. active is never 0 in RUN, so there is no underflow.
  - Maximum period 2^DELAY_W-1; count never wraps.
- Simultaneous enable=0 and terminal count in RUN: enable has priority, so no tick and no toggle.
- running = (state!=IDLE), registered with the state.
- Reset asserted mid-period: immediate return to reset values, with no tick emitted.

Decomposition:
- Shared package pulse_delay_pkg holds:
  - state enum (IDLE, LOAD, RUN), 2-bit encoding;
  - default DELAY_W constant, shared with the PIO-width definition.
- No sub-module. The block is a single FSM plus counter; splitting it adds nothing.

Test Plan:
- Reset with delay_in=4, enable=0 -> tick=0, led_out=0, running=0, cur_count=0 for 20 cycles.
- delay_in=4, enable raised and held -> first tick 6 cycles after enable is sampled, then every 4 cycles; led_out toggles at each tick; tick width exactly 1 cycle.
- delay_in=1, enable=1 -> tick continuously high after startup; led_out toggles every cycle.
- Running with delay 10; change delay_in to 3 at count=2 -> current period still ends at count=9 (10 cycles), then ticks every 3 cycles.
- Running with delay 5; set delay_in=0 mid-period -> one final tick at the period end, then running=0, no further ticks, led_out holds.
- Running with delay 8; drop enable at count=7 (terminal cycle) -> no tick, no toggle, IDLE next cycle. Re-enable -> full 8-cycle period after LOAD.
